shift_add_ctrl: RTL and testbench
=================================

// Module: shift_add_ctrl
// PURPOSE
//  Sequencer for the serial shift-add datapath (ADD_SEQ). Accepts one job via Start:
//  a parallel coefficient and an operand. Per job it clears the datapath, parallel-loads
//  the coefficient, then streams the operand LSB-first on SerialIn with EnableShiftAdd high.
//  It then captures ParallelOut into Result and pulses Done. Sits between the host logic
//  and ADD_SEQ; ADD_SEQ is never driven directly by the host.
// PARAMETERS
//  DATA_W   8  width of coefficient, operand, ParallelOut and Result
//  CNT_W    4  width of bit counter; must hold DATA_W
// PORTS
//  Clock           in   1       rising-edge clock
//  Reset           in   1       asynchronous, active-high reset
//  Start           in   1       job request; sampled only in IDLE
//  Abort           in   1       cancels a running job
//  Coeff           in   DATA_W  coefficient for ParaLoad
//  Operand         in   DATA_W  serial operand, shifted out LSB first
//  Len             in   CNT_W   bits to shift; 0 or >DATA_W means DATA_W
//  ParallelOut     in   DATA_W  datapath result
//  DpReset_n       out  1       datapath clear, active low
//  ParaLoad        out  1       datapath parallel-load strobe
//  CoeffData       out  DATA_W  datapath coefficient bus
//  SerialIn        out  1       datapath serial bit
//  EnableShiftAdd  out  1       datapath shift/add enable
//  Busy            out  1       job in progress
//  Done            out  1       one-cycle completion pulse
//  Result          out  DATA_W  captured ParallelOut; held until the next capture
// BEHAVIOUR
//  - Moore FSM; all outputs registered. States: IDLE, CLEAR, LOAD, SHIFT, SETTLE, DONE.
//  - Reset (async): state=IDLE; DpReset_n=1; ParaLoad=0; EnableShiftAdd=0; SerialIn=0.
//    Also CoeffData=0, Busy=0, Done=0, Result=0; internal op reg and counter cleared.
//  - IDLE: Busy=0. At a Start=1 edge, latch Coeff, Operand and the clamped Len
//    (Leff in 1..DATA_W), then go to CLEAR.
//  - CLEAR (1 cycle): DpReset_n=0, Busy=1; next state LOAD.
//  - LOAD (1 cycle): ParaLoad=1, CoeffData=latched Coeff; next state SHIFT.
//  - SHIFT (exactly Leff cycles): EnableShiftAdd=1, SerialIn=opreg[0].
//    Each edge shifts opreg right (zero fill) and increments cnt.
//    After the Leff-th bit, go to SETTLE.
//  - SETTLE (1 cycle): enable low; lets ParallelOut absorb the last bit.
//  - DONE (1 cycle): Result<=ParallelOut, Done=1, Busy=1; next state IDLE.
//  - CoeffData holds the latched Coeff from LOAD through DONE; it returns to 0 in IDLE.
//  - SerialIn=0 whenever EnableShiftAdd=0.
//  - Latency: Start edge t0 -> CLEAR t0..t1 -> LOAD t1..t2 -> SHIFT t2..t2+Leff
//    -> SETTLE -> Done high during cycle t2+Leff+1; Start-to-Done = Leff+3 edges.
//  - Start while Busy is ignored (no queueing). Start held high re-triggers in the IDLE
//    cycle after DONE.
//  - Abort=1 in any non-IDLE state: next edge -> IDLE. All strobes drop, no Done pulse,
//    Result unchanged, DpReset_n=1.
//  - Abort and Start high together in IDLE: Abort wins and the job is not accepted.
//  - Abort in DONE: Done still completes this cycle (capture already committed).
//  - Reset mid-job: immediate return to reset values; the datapath is left unenabled.
//  - ParaLoad, DpReset_n=0 and EnableShiftAdd are mutually exclusive; never two high
//    in one cycle.
// TESTING
//  T1 Reset asserted mid-SHIFT -> all outputs at reset values asynchronously; Busy=0
//     until a new Start.
//  T2 Coeff=0x56, Operand=0x4D, Len=8, Start 1 cycle -> DpReset_n low 1 cycle; then
//     ParaLoad high 1 cycle with CoeffData=0x56. SerialIn must be 1,0,1,1,0,0,1,0
//     over 8 EnableShiftAdd cycles; Done at edge 11.
//  T3 Stub ParallelOut=0xA5 during SETTLE/DONE -> Result=0xA5 when Done=1, held after.
//     Then Len=0 -> 8 shift cycles; Len=3 -> 3 shift cycles, Done at edge 6.
//  T4 Start pulsed again during SHIFT -> ignored; exactly one Done. Start held high
//     -> back-to-back jobs with a 1-cycle IDLE gap.
//  T5 Abort on 4th SHIFT cycle -> EnableShiftAdd low next edge, no Done, Result keeps
//     previous value. Abort+Start together in IDLE -> Busy stays 0.
//  T6 Check every cycle that no two of ParaLoad, ~DpReset_n, EnableShiftAdd are high
//     together; SerialIn=0 when not enabled.

Source files
------------

// File: rtl/shift_add_ctrl_if.sv
// shift_add_ctrl_if
//   Bundles the host job handshake and the ADD_SEQ datapath bus seen by the
//   shift_add_ctrl sequencer.
//   Host side      : Start, Abort, Coeff, Operand, Len  -> sequencer
//                    Busy, Done, Result                 <- sequencer
//   Datapath side  : ParallelOut                        -> sequencer
//                    DpReset_n, ParaLoad, CoeffData,
//                    SerialIn, EnableShiftAdd           <- sequencer
//   slave  : the sequencer's view
//   master : the environment's view (host logic plus datapath)
interface shift_add_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4
);
    // host job request
    logic              Start;
    logic              Abort;
    logic [DATA_W-1:0] Coeff;
    logic [DATA_W-1:0] Operand;
    logic [CNT_W-1:0]  Len;
    // host status / result
    logic              Busy;
    logic              Done;
    logic [DATA_W-1:0] Result;
    // datapath bus
    logic [DATA_W-1:0] ParallelOut;
    logic              DpReset_n;
    logic              ParaLoad;
    logic [DATA_W-1:0] CoeffData;
    logic              SerialIn;
    logic              EnableShiftAdd;

    modport slave (
        input  Start, Abort, Coeff, Operand, Len, ParallelOut,
        output Busy, Done, Result,
        output DpReset_n, ParaLoad, CoeffData, SerialIn, EnableShiftAdd
    );

    modport master (
        output Start, Abort, Coeff, Operand, Len, ParallelOut,
        input  Busy, Done, Result,
        input  DpReset_n, ParaLoad, CoeffData, SerialIn, EnableShiftAdd
    );
endinterface

// File: rtl/shift_add_ctrl.sv
// shift_add_ctrl
//   Sequencer for the serial shift-add datapath (ADD_SEQ). One job per Start:
//   clear the datapath, parallel-load the coefficient, stream the operand
//   LSB-first with EnableShiftAdd high, let the datapath settle, then capture
//   ParallelOut into Result and pulse Done.
//   Ports:
//     Clock : rising-edge clock
//     Reset : asynchronous, active-high reset
//     bus   : shift_add_ctrl_if.slave (host handshake + datapath bus)
//   All outputs are registered; the FSM writes next-state outputs on the same
//   edge it changes state, so each output is a clean function of the state.
module shift_add_ctrl #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    shift_add_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        SHIFT,
        SETTLE,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] FULL_LEN = CNT_W'(DATA_W);

    state_t            state;
    logic [DATA_W-1:0] coeff_q;
    logic [DATA_W-1:0] opreg;
    logic [CNT_W-1:0]  leff;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  len_clamped;

    // Zero or out-of-range lengths mean a full-width job.
    always_comb begin
        len_clamped = bus.Len;
        if (bus.Len == '0 || bus.Len > FULL_LEN)
            len_clamped = FULL_LEN;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state              <= IDLE;
            coeff_q            <= '0;
            opreg              <= '0;
            leff               <= '0;
            cnt                <= '0;
            bus.DpReset_n      <= 1'b1;
            bus.ParaLoad       <= 1'b0;
            bus.CoeffData      <= '0;
            bus.SerialIn       <= 1'b0;
            bus.EnableShiftAdd <= 1'b0;
            bus.Busy           <= 1'b0;
            bus.Done           <= 1'b0;
            bus.Result         <= '0;
        end else begin
            // Strobes are single-state; default them off so at most one of
            // DpReset_n low / ParaLoad / EnableShiftAdd is ever asserted.
            bus.DpReset_n      <= 1'b1;
            bus.ParaLoad       <= 1'b0;
            bus.SerialIn       <= 1'b0;
            bus.EnableShiftAdd <= 1'b0;
            bus.Done           <= 1'b0;

            if (state != IDLE && bus.Abort) begin
                // Cancel: no capture, no Done, Result keeps its old value.
                // From DONE this is indistinguishable from the normal exit.
                state         <= IDLE;
                bus.Busy      <= 1'b0;
                bus.CoeffData <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (bus.Start && !bus.Abort) begin
                            coeff_q       <= bus.Coeff;
                            opreg         <= bus.Operand;
                            leff          <= len_clamped;
                            cnt           <= '0;
                            state         <= CLEAR;
                            bus.DpReset_n <= 1'b0;
                            bus.Busy      <= 1'b1;
                        end else begin
                            bus.Busy      <= 1'b0;
                            bus.CoeffData <= '0;
                        end
                    end
                    CLEAR: begin
                        state         <= LOAD;
                        bus.ParaLoad  <= 1'b1;
                        bus.CoeffData <= coeff_q;
                    end
                    LOAD: begin
                        // First serial bit is presented on entry to SHIFT.
                        state              <= SHIFT;
                        bus.EnableShiftAdd <= 1'b1;
                        bus.SerialIn       <= opreg[0];
                        opreg              <= opreg >> 1;
                        cnt                <= CNT_W'(1);
                    end
                    SHIFT: begin
                        // cnt counts bits already presented; leave once the
                        // Leff-th bit has had its enabled cycle.
                        if (cnt == leff) begin
                            state <= SETTLE;
                        end else begin
                            bus.EnableShiftAdd <= 1'b1;
                            bus.SerialIn       <= opreg[0];
                            opreg              <= opreg >> 1;
                            cnt                <= cnt + CNT_W'(1);
                        end
                    end
                    SETTLE: begin
                        // Capture on the edge into DONE so Result is already
                        // valid while Done is high.
                        state      <= DONE;
                        bus.Done   <= 1'b1;
                        bus.Result <= bus.ParallelOut;
                    end
                    DONE: begin
                        state         <= IDLE;
                        bus.Busy      <= 1'b0;
                        bus.CoeffData <= '0;
                    end
                    default: begin
                        state         <= IDLE;
                        bus.Busy      <= 1'b0;
                        bus.CoeffData <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_shift_add_ctrl.sv
module tb_shift_add_ctrl;

    logic Clock = 1'b0;
    logic Reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   done_cnt = 0;
    logic [7:0] sb[$];
    logic [7:0] last_result;

    always #5 Clock = ~Clock;

    shift_add_ctrl_if #(.DATA_W(8), .CNT_W(4)) bus ();

    shift_add_ctrl #(.DATA_W(8), .CNT_W(4)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer and per-cycle protocol invariants.
    always @(negedge Clock) begin
        if (!Reset) begin
            chk("strobe_excl",
                32'(int'(bus.ParaLoad) + int'(!bus.DpReset_n) + int'(bus.EnableShiftAdd) > 1), 0);
            chk("serial_idle", 32'(bus.SerialIn && !bus.EnableShiftAdd), 0);
            if (bus.Done === 1'b1) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    chk("result_on_done", bus.Result, sb.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic run_job(input logic [7:0] c, input logic [7:0] op, input logic [3:0] len,
                           input logic [7:0] po, input bit poke);
        int leff;
        int d0;
        leff = (len == 0 || len > 8) ? 8 : int'(len);
        d0 = done_cnt;
        bus.Coeff = c; bus.Operand = op; bus.Len = len; bus.ParallelOut = 8'h00; bus.Start = 1'b1;
        sb.push_back(po);
        @(negedge Clock);
        bus.Start = 1'b0;
        chk("clear_dprst", bus.DpReset_n, 0);
        chk("clear_busy", bus.Busy, 1);
        chk("clear_pl", bus.ParaLoad, 0);
        @(negedge Clock);
        chk("load_pl", bus.ParaLoad, 1);
        chk("load_coeff", bus.CoeffData, c);
        chk("load_dprst", bus.DpReset_n, 1);
        for (int i = 0; i < leff; i++) begin
            @(negedge Clock);
            chk("shift_en", bus.EnableShiftAdd, 1);
            chk("shift_bit", bus.SerialIn, op[i]);
            chk("shift_coeff", bus.CoeffData, c);
            if (poke && i == 1) begin
                bus.Start = 1'b1; bus.Coeff = ~c;
            end else begin
                bus.Start = 1'b0;
            end
        end
        @(negedge Clock);
        bus.Start = 1'b0;
        chk("settle_en", bus.EnableShiftAdd, 0);
        chk("settle_done", bus.Done, 0);
        bus.ParallelOut = po;
        @(negedge Clock);
        chk("done_pulse", bus.Done, 1);
        chk("done_busy", bus.Busy, 1);
        @(negedge Clock);
        chk("idle_done", bus.Done, 0);
        chk("idle_busy", bus.Busy, 0);
        chk("idle_coeff", bus.CoeffData, 0);
        bus.ParallelOut = ~po;
        @(negedge Clock);
        @(negedge Clock);
        chk("result_hold", bus.Result, po);
        chk("one_done", done_cnt - d0, 1);
        chk("stay_idle", bus.Busy, 0);
        last_result = po;
    endtask

    initial begin
        Reset = 1'b1;
        bus.Start = 1'b0; bus.Abort = 1'b0; bus.Coeff = '0; bus.Operand = '0;
        bus.Len = '0; bus.ParallelOut = '0;
        @(negedge Clock);
        @(negedge Clock);
        chk("rst_dprst", bus.DpReset_n, 1);
        chk("rst_pl", bus.ParaLoad, 0);
        chk("rst_en", bus.EnableShiftAdd, 0);
        chk("rst_busy", bus.Busy, 0);
        chk("rst_result", bus.Result, 0);
        Reset = 1'b0;
        @(negedge Clock);

        // Spec example job, then capture/hold and length boundaries
        run_job(8'h56, 8'h4D, 4'd8, 8'h5A, 1'b0);
        run_job(8'h12, 8'hB3, 4'd8, 8'hA5, 1'b0);
        run_job(8'h9C, 8'h6E, 4'd0, 8'h3C, 1'b0);
        run_job(8'h21, 8'h05, 4'd3, 8'h7E, 1'b0);
        run_job(8'hF0, 8'hC9, 4'd12, 8'h81, 1'b0);
        run_job(8'h0F, 8'h80, 4'd1, 8'h11, 1'b0);
        // Start during SHIFT is ignored
        run_job(8'h33, 8'hD2, 4'd5, 8'h44, 1'b1);

        // Asynchronous reset mid-SHIFT
        bus.Coeff = 8'h77; bus.Operand = 8'hFF; bus.Len = 4'd8; bus.Start = 1'b1;
        @(negedge Clock);
        bus.Start = 1'b0;
        repeat (4) @(negedge Clock);
        chk("pre_rst_en", bus.EnableShiftAdd, 1);
        #2 Reset = 1'b1;
        #1;
        chk("arst_en", bus.EnableShiftAdd, 0);
        chk("arst_serial", bus.SerialIn, 0);
        chk("arst_busy", bus.Busy, 0);
        chk("arst_coeff", bus.CoeffData, 0);
        chk("arst_result", bus.Result, 0);
        chk("arst_dprst", bus.DpReset_n, 1);
        @(negedge Clock);
        Reset = 1'b0;
        repeat (3) @(negedge Clock);
        chk("post_rst_busy", bus.Busy, 0);
        last_result = 8'h00;

        // Start held high: back-to-back jobs with one IDLE cycle between
        bus.Coeff = 8'h19; bus.Operand = 8'h06; bus.Len = 4'd3; bus.ParallelOut = 8'h3C;
        bus.Start = 1'b1;
        sb.push_back(8'h3C); sb.push_back(8'h3C);
        for (int k = 0; k <= 15; k++) begin
            @(negedge Clock);
            case (k)
                0:  chk("b2b_clear0", bus.DpReset_n, 0);
                6:  chk("b2b_done0", bus.Done, 1);
                7:  begin chk("b2b_gap_busy", bus.Busy, 0); chk("b2b_gap_done", bus.Done, 0); end
                8:  begin chk("b2b_clear1", bus.DpReset_n, 0); chk("b2b_busy1", bus.Busy, 1);
                          bus.Start = 1'b0; end
                14: chk("b2b_done1", bus.Done, 1);
                15: chk("b2b_idle", bus.Busy, 0);
                default: ;
            endcase
        end
        last_result = 8'h3C;

        // Abort on the 4th SHIFT cycle
        begin
            int d0;
            d0 = done_cnt;
            bus.Coeff = 8'hAA; bus.Operand = 8'h5B; bus.Len = 4'd8; bus.ParallelOut = 8'hEE;
            bus.Start = 1'b1;
            @(negedge Clock);
            bus.Start = 1'b0;
            repeat (4) @(negedge Clock);
            @(negedge Clock);
            chk("abort_pre_en", bus.EnableShiftAdd, 1);
            bus.Abort = 1'b1;
            @(negedge Clock);
            bus.Abort = 1'b0;
            chk("abort_en", bus.EnableShiftAdd, 0);
            chk("abort_busy", bus.Busy, 0);
            chk("abort_dprst", bus.DpReset_n, 1);
            chk("abort_coeff", bus.CoeffData, 0);
            repeat (12) @(negedge Clock);
            chk("abort_no_done", done_cnt - d0, 0);
            chk("abort_result", bus.Result, last_result);
        end

        // Abort and Start together in IDLE
        bus.Abort = 1'b1; bus.Start = 1'b1;
        @(negedge Clock);
        chk("abst_busy", bus.Busy, 0);
        chk("abst_dprst", bus.DpReset_n, 1);
        bus.Abort = 1'b0; bus.Start = 1'b0;
        @(negedge Clock);
        chk("abst_busy2", bus.Busy, 0);

        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
